// File: rtl/cache_pkg.sv
// Shared definitions for the cache tag directory slice.
//   DEF_SETS / DEF_WAYS / DEF_TAG_W : default geometry of the directory
//   dir_state_e                     : directory controller states
package cache_pkg;

    localparam int unsigned DEF_SETS  = 128;
    localparam int unsigned DEF_WAYS  = 4;
    localparam int unsigned DEF_TAG_W = 19;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_READY = 1'b1
    } dir_state_e;

endpackage

// File: rtl/plru_tree.sv
// Tree pseudo-LRU helper for one set of a WAYS-way directory.
// Node bits are stored heap-ordered (root at bit 0, children of node n at
// 2n+1 / 2n+2); a bit value of 0 points at the left subtree as the
// least-recently-used side, 1 at the right subtree.
//   lk_bits       : PLRU bits of the looked-up set
//   lk_victim     : way the tree currently selects for replacement
//   hit_way       : way accessed by a lookup hit
//   hit_bits      : lk_bits after an access to hit_way
//   upd_bits      : PLRU bits of the set being updated
//   upd_way       : way written by the update
//   upd_bits_next : upd_bits after an access to upd_way
module plru_tree #(
    parameter  int unsigned WAYS  = cache_pkg::DEF_WAYS,
    localparam int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic [WAYS-2:0]  lk_bits,
    output logic [WAY_W-1:0] lk_victim,
    input  logic [WAY_W-1:0] hit_way,
    output logic [WAYS-2:0]  hit_bits,
    input  logic [WAYS-2:0]  upd_bits,
    input  logic [WAY_W-1:0] upd_way,
    output logic [WAYS-2:0]  upd_bits_next
);

    // Walk from the root following the stored direction bits. The node
    // number (1-based heap index) shifted left with the direction appended
    // ends up as WAYS + way, so its low WAY_W bits are the way itself.
    function automatic logic [WAY_W-1:0] victim_of(input logic [WAYS-2:0] bits);
        logic [WAYS-1:0]  tree;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] pos;
        tree = {1'b0, bits};
        node = WAY_W'(1);
        for (int unsigned l = 0; l < WAY_W; l++) begin
            pos  = node - 1'b1;
            node = (node << 1) | WAY_W'(tree[pos]);
        end
        return node;
    endfunction

    // Walk the path to way w (MSB first), pointing every node on it away
    // from the direction taken.
    function automatic logic [WAYS-2:0] bits_after(input logic [WAYS-2:0] bits,
                                                   input logic [WAY_W-1:0] w);
        logic [WAYS-1:0]  tree;
        logic [WAY_W-1:0] node;
        logic [WAY_W-1:0] pos;
        logic [WAY_W-1:0] ws;
        tree = {1'b0, bits};
        node = WAY_W'(1);
        ws   = w;
        for (int unsigned l = 0; l < WAY_W; l++) begin
            pos       = node - 1'b1;
            tree[pos] = ~ws[WAY_W-1];
            node      = (node << 1) | WAY_W'(ws[WAY_W-1]);
            ws        = ws << 1;
        end
        return tree[WAYS-2:0];
    endfunction

    assign lk_victim     = victim_of(lk_bits);
    assign hit_bits      = bits_after(lk_bits, hit_way);
    assign upd_bits_next = bits_after(upd_bits, upd_way);

endmodule

// File: rtl/tag_directory.sv
// Set-associative tag directory with tree-PLRU replacement.
// After reset or a flush request the directory sweeps every set (one per
// cycle), clearing valid/dirty/PLRU state, then accepts lookups.
//   clk, rst_n             : clock, asynchronous active-low reset
//   flush_req / busy       : invalidate-all request / sweep in progress
//   lk_valid / lk_ready    : lookup handshake; lk_index, lk_tag lookup key
//   rsp_valid              : one-cycle result pulse, one cycle after accept
//   rsp_hit/way/dirty      : hit result for the lookup
//   rsp_vic_way/tag/valid/dirty : replacement victim and its current state
//   upd_en, upd_*          : write tag/valid/dirty into [upd_index][upd_way]
module tag_directory
    import cache_pkg::*;
#(
    parameter  int unsigned SETS  = cache_pkg::DEF_SETS,
    parameter  int unsigned WAYS  = cache_pkg::DEF_WAYS,
    parameter  int unsigned TAG_W = cache_pkg::DEF_TAG_W,
    localparam int unsigned IDX_W = $clog2(SETS),
    localparam int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_req,
    output logic             busy,
    input  logic             lk_valid,
    output logic             lk_ready,
    input  logic [IDX_W-1:0] lk_index,
    input  logic [TAG_W-1:0] lk_tag,
    output logic             rsp_valid,
    output logic             rsp_hit,
    output logic [WAY_W-1:0] rsp_way,
    output logic             rsp_dirty,
    output logic [WAY_W-1:0] rsp_vic_way,
    output logic [TAG_W-1:0] rsp_vic_tag,
    output logic             rsp_vic_valid,
    output logic             rsp_vic_dirty,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_index,
    input  logic [WAY_W-1:0] upd_way,
    input  logic [TAG_W-1:0] upd_tag,
    input  logic             upd_valid,
    input  logic             upd_dirty
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SETS - 1);

    // Directory storage
    logic [TAG_W-1:0] tag_mem   [SETS][WAYS];
    logic [WAYS-1:0]  valid_mem [SETS];
    logic [WAYS-1:0]  dirty_mem [SETS];
    logic [WAYS-2:0]  plru_mem  [SETS];

    dir_state_e       state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;

    logic accept;
    logic upd_act;

    // Looked-up set as seen after any same-cycle update
    logic [TAG_W-1:0] set_tag [WAYS];
    logic [WAYS-1:0]  set_valid;
    logic [WAYS-1:0]  set_dirty;
    logic [WAYS-2:0]  set_plru;

    logic [WAYS-2:0]  upd_cur_plru;
    logic [WAYS-2:0]  upd_new_plru;
    logic [WAYS-2:0]  hit_new_plru;
    logic [WAY_W-1:0] plru_victim;

    logic             hit;
    logic [WAY_W-1:0] hit_way;
    logic             inv_found;
    logic [WAY_W-1:0] inv_way;
    logic [WAY_W-1:0] vic_way;

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FLUSH;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        busy     = 1'b0;
        lk_ready = 1'b0;
        unique case (state_q)
            ST_FLUSH: begin
                busy    = 1'b1;
                sweep_d = sweep_q + 1'b1;
                if (sweep_q == LAST_IDX) begin
                    state_d = ST_READY;
                end
            end
            ST_READY: begin
                lk_ready = 1'b1;
                sweep_d  = '0;
                if (flush_req) begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_FLUSH;
                sweep_d = '0;
            end
        endcase
    end

    assign accept  = lk_valid && lk_ready;
    assign upd_act = upd_en && lk_ready;

    // ------------------------------------------------------ set read view
    assign upd_cur_plru = plru_mem[upd_index];

    // Write-first bypass: a same-cycle update to the looked-up set is
    // merged here, including its PLRU effect, before hit/victim selection.
    always_comb begin
        for (int unsigned w = 0; w < WAYS; w++) begin
            set_tag[w] = tag_mem[lk_index][w];
        end
        set_valid = valid_mem[lk_index];
        set_dirty = dirty_mem[lk_index];
        set_plru  = plru_mem[lk_index];
        if (upd_act && (upd_index == lk_index)) begin
            set_tag[upd_way]   = upd_tag;
            set_valid[upd_way] = upd_valid;
            set_dirty[upd_way] = upd_dirty;
            set_plru           = upd_new_plru;
        end
    end

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit && set_valid[w] && (set_tag[w] == lk_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !set_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        vic_way = inv_found ? inv_way : plru_victim;
    end

    plru_tree #(
        .WAYS (WAYS)
    ) u_plru (
        .lk_bits       (set_plru),
        .lk_victim     (plru_victim),
        .hit_way       (hit_way),
        .hit_bits      (hit_new_plru),
        .upd_bits      (upd_cur_plru),
        .upd_way       (upd_way),
        .upd_bits_next (upd_new_plru)
    );

    // ----------------------------------------------------------- storage
    // No reset here: the sweep clears valid/dirty/PLRU before any lookup is
    // accepted, and tags are never cleared. The update PLRU write comes last
    // so it takes priority over a hit on the same set.
    always_ff @(posedge clk) begin
        if (busy) begin
            valid_mem[sweep_q] <= '0;
            dirty_mem[sweep_q] <= '0;
            plru_mem[sweep_q]  <= '0;
        end
        if (accept && hit) begin
            plru_mem[lk_index] <= hit_new_plru;
        end
        if (upd_act) begin
            tag_mem[upd_index][upd_way]   <= upd_tag;
            valid_mem[upd_index][upd_way] <= upd_valid;
            dirty_mem[upd_index][upd_way] <= upd_dirty;
            plru_mem[upd_index]           <= upd_new_plru;
        end
    end

    // ---------------------------------------------------------- response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid     <= 1'b0;
            rsp_hit       <= 1'b0;
            rsp_way       <= '0;
            rsp_dirty     <= 1'b0;
            rsp_vic_way   <= '0;
            rsp_vic_tag   <= '0;
            rsp_vic_valid <= 1'b0;
            rsp_vic_dirty <= 1'b0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                rsp_hit       <= hit;
                rsp_way       <= hit_way;
                rsp_dirty     <= hit & set_dirty[hit_way];
                rsp_vic_way   <= vic_way;
                rsp_vic_tag   <= set_tag[vic_way];
                rsp_vic_valid <= set_valid[vic_way];
                rsp_vic_dirty <= set_dirty[vic_way];
            end
        end
    end

endmodule

// File: doc/tag_directory.md
TAG_DIRECTORY -- requirements
Module: tag_directory

Interface
REQ-001 SHALL have parameter SETS, default 128, number of sets; power of 2, at least 2.
REQ-002 SHALL have parameter WAYS, default 4, associativity; power of 2, from 2 to 16.
REQ-003 SHALL have parameter TAG_W, default 19, tag width in bits.
REQ-004 SHALL derive IDX_W = $clog2(SETS) and WAY_W = $clog2(WAYS); these are not overridable.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 flush_req  input  1  one-cycle pulse requesting invalidation of every line.
REQ-008 busy  output  1  high while a flush sweep is in progress.
REQ-009 lk_valid / lk_ready  input / output  1 / 1  lookup request handshake.
REQ-010 lk_index / lk_tag  input  IDX_W / TAG_W  lookup set index and tag.
REQ-011 rsp_valid  output  1  lookup result valid; one-cycle pulse.
REQ-012 rsp_hit / rsp_way / rsp_dirty  output  1 / WAY_W / 1  hit flag, hitting way, and dirty bit of the hitting way.
REQ-013 rsp_vic_way / rsp_vic_tag / rsp_vic_valid / rsp_vic_dirty  output  WAY_W / TAG_W / 1 / 1  replacement victim and its current state.
REQ-014 upd_en  input  1  line update strobe.
REQ-015 upd_index / upd_way / upd_tag / upd_valid / upd_dirty  input  IDX_W / WAY_W / TAG_W / 1 / 1  line fields to write.

Function
REQ-016 SHALL store, per set and way, a tag, a valid bit and a dirty bit; SHALL store WAYS-1 tree-PLRU bits per set.
REQ-017 SHALL implement a two-state FSM, FLUSH and READY. FLUSH -> READY after the set with index SETS-1 is cleared. READY -> FLUSH on flush_req.
REQ-018 In FLUSH, SHALL clear valid, dirty and PLRU bits of one set per cycle, starting at index 0, taking exactly SETS cycles; tags are left unchanged.
REQ-019 busy SHALL equal (state == FLUSH). lk_ready SHALL equal (state == READY).
REQ-020 SHALL ignore upd_en while busy, and SHALL ignore flush_req while busy.
REQ-021 A lookup is accepted when lk_valid && lk_ready. rsp_valid SHALL assert exactly 1 cycle after acceptance, and one lookup SHALL be accepted per cycle.
REQ-022 rsp_hit SHALL be 1 when some valid way in the set has a tag equal to lk_tag; rsp_way SHALL be the lowest such way; rsp_way = 0 on a miss.
REQ-023 The victim SHALL be the lowest-numbered invalid way if any way is invalid, otherwise the way selected by the PLRU tree; rsp_vic_* SHALL give that way's stored tag, valid bit and dirty bit.
REQ-024 On a hit, SHALL update that set's PLRU bits on the response edge so that they point away from rsp_way; a miss SHALL leave the PLRU bits unchanged.
REQ-025 An update (upd_en in READY) SHALL write tag, valid and dirty to [upd_index][upd_way] on the same edge, and SHALL mark that way most-recently-used in PLRU.
REQ-026 If an update and a lookup acceptance target the same set in the same cycle, the response SHALL reflect the post-update contents (write-first bypass).
REQ-027 If a hit PLRU update and an update-driven PLRU update hit the same set on the same edge, the upd_way update SHALL win.
REQ-028 flush_req in the same cycle as a lookup acceptance: the lookup SHALL still respond next cycle with pre-flush contents.
REQ-029 A flush_req pulse arriving while a response is in flight SHALL not suppress that response.

Reset
REQ-030 On rst_n low, state SHALL be FLUSH with the sweep index at 0, and rsp_valid SHALL be 0; all other rsp_* outputs SHALL be 0.
REQ-031 After rst_n deasserts, SHALL complete a full sweep, so lk_ready is 0 for SETS cycles after reset.
REQ-032 The tag storage SHALL have no reset, so that it can be inferred as RAM.

Structure
REQ-033 A shared package cache_pkg SHALL hold the default SETS, WAYS and TAG_W values and the FSM state enum.
REQ-034 SHALL instantiate one sub-module, plru_tree, parameterised by WAYS, with functions "victim from bits" and "bits after access to way w".

Verification
REQ-035 Reset release: rst_n high -> busy=1 for exactly 128 cycles, then lk_ready=1.
REQ-036 Fill and hit: upd index 5, way 2, tag 0x1ABCD, valid=1; lookup index 5, tag 0x1ABCD -> next cycle rsp_hit=1, rsp_way=2, rsp_dirty=0.
REQ-037 Victim order: fill ways 0-3 of set 9 in the order 0, 1, 2, 3 -> lookup miss returns rsp_vic_way=0 and rsp_vic_valid=1; after a hit on way 0, the next miss returns rsp_vic_way=2.
REQ-038 Bypass: same-cycle upd (set 3, way 1, tag 0x7, dirty=1) and lookup (set 3, tag 0x7) -> rsp_hit=1, rsp_way=1, rsp_dirty=1.
REQ-039 Flush: after the fills above, pulse flush_req -> busy for 128 cycles, then every lookup returns rsp_hit=0 and rsp_vic_way=0 with rsp_vic_valid=0.
REQ-040 Reset mid-flush: assert rst_n low at sweep index 40 -> after release, the sweep restarts at index 0 and lasts 128 cycles.
